// File: rtl/seg_scan_mux_pkg.sv
// rtl/seg_scan_mux_pkg.sv - shared constants for the traffic-light countdown display
//
// Purpose:
//   Segment patterns for BCD digits, digit slot indices and the scan FSM
//   state encoding used by seg_scan_mux.
//   Segment vectors are ordered {g,f,e,d,c,b,a}. In this package they are
//   active-high (1 = lit); polarity is applied in seg_scan_mux.

package seg_scan_mux_pkg;

  // Scan FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  // Slot order on the shared segment bus
  localparam logic [1:0] D_ONE1 = 2'd0;
  localparam logic [1:0] D_TEN1 = 2'd1;
  localparam logic [1:0] D_ONE2 = 2'd2;
  localparam logic [1:0] D_TEN2 = 2'd3;

  // Active-high patterns, {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0   = 7'b0111111;
  localparam logic [6:0] SEG_1   = 7'b0000110;
  localparam logic [6:0] SEG_2   = 7'b1011011;
  localparam logic [6:0] SEG_3   = 7'b1001111;
  localparam logic [6:0] SEG_4   = 7'b1100110;
  localparam logic [6:0] SEG_5   = 7'b1101101;
  localparam logic [6:0] SEG_6   = 7'b1111101;
  localparam logic [6:0] SEG_7   = 7'b0000111;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1101111;
  localparam logic [6:0] SEG_NONE = 7'b0000000;

  // BCD to active-high segments; codes 10..15 are not digits and stay dark
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] i_bcd);
    logic [6:0] w_pat;
    case (i_bcd)
      4'd0:    w_pat = SEG_0;
      4'd1:    w_pat = SEG_1;
      4'd2:    w_pat = SEG_2;
      4'd3:    w_pat = SEG_3;
      4'd4:    w_pat = SEG_4;
      4'd5:    w_pat = SEG_5;
      4'd6:    w_pat = SEG_6;
      4'd7:    w_pat = SEG_7;
      4'd8:    w_pat = SEG_8;
      4'd9:    w_pat = SEG_9;
      default: w_pat = SEG_NONE;
    endcase
    return w_pat;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - digit slot counter with blank-end and slot-end strobes
//
// Purpose:
//   Counts 0..DIV-1 while i_run is high and wraps; held at 0 while i_run is low
//   (synchronous clear). Strobes are combinational decodes of the count and
//   are only asserted while running.
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   i_run        in   1 = count, 0 = clear to 0 on the next edge
//   o_blank_end  out  count == BLANK_CYCLES-1 (last dark cycle of the slot)
//   o_pre_end    out  count == DIV-2 (cycle before the last cycle of the slot)
//   o_slot_end   out  count == DIV-1 (last cycle of the slot)

module scan_tick_gen #(
  parameter int DIV          = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  output logic o_blank_end,
  output logic o_pre_end,
  output logic o_slot_end
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST_CNT  = CW'(DIV - 1);
  localparam logic [CW-1:0] PRE_CNT   = CW'(DIV - 2);
  localparam logic [CW-1:0] BLANK_CNT = CW'(BLANK_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_run || (r_cnt == LAST_CNT)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_blank_end = i_run && (r_cnt == BLANK_CNT);
  assign o_pre_end   = i_run && (r_cnt == PRE_CNT);
  assign o_slot_end  = i_run && (r_cnt == LAST_CNT);

endmodule

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - 4-digit time-multiplexed 7-segment driver for two countdowns
//
// Purpose:
//   Scans one1, ten1, one2, ten2 onto a shared segment bus, one slot each.
//   Every slot opens with BLANK_CYCLES dark cycles (anti-ghosting), then the
//   digit is shown until the slot ends. All four digits are latched together
//   at frame start so a frame never mixes old and new values. A tens digit of
//   0 is blanked when LZ_BLANK is set; non-BCD codes show dark.
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   en          in   display enable; 0 forces dark and restarts the scan
//   one1/ten1   in   BCD digits, road 1
//   one2/ten2   in   BCD digits, road 2
//   seg         out  {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW (registered)
//   an          out  digit enables, one-hot when lit, polarity per AN_ACTIVE_LOW (registered)
//   digit_idx   out  slot in progress (0=one1, 1=ten1, 2=one2, 3=ten2)
//   frame_done  out  one-cycle pulse on the last cycle of slot 3

import seg_scan_mux_pkg::*;

module seg_scan_mux #(
  parameter int CLK_HZ         = 50000000,
  parameter int SCAN_HZ        = 1000,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit LZ_BLANK       = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] one1,
  input  logic [3:0] ten1,
  input  logic [3:0] one2,
  input  logic [3:0] ten2,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic [1:0] digit_idx,
  output logic       frame_done
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;

  scan_state_t r_state;
  logic [1:0]  r_idx;
  logic        r_frame_done;
  logic [6:0]  r_seg;
  logic [3:0]  r_an;
  logic [3:0]  r_snap_one1;
  logic [3:0]  r_snap_ten1;
  logic [3:0]  r_snap_one2;
  logic [3:0]  r_snap_ten2;

  logic        w_run;
  logic        w_blank_end;
  logic        w_pre_end;
  logic        w_slot_end;
  logic        w_take_snap;
  logic [3:0]  w_bcd;
  logic [6:0]  w_pat;
  logic [6:0]  w_seg_lit;
  logic [3:0]  w_an_onehot;
  logic [3:0]  w_an_lit;

  // The counter only runs once the FSM has left IDLE, so BLANK always
  // starts at count 0.
  assign w_run = en && (r_state != ST_IDLE);

  scan_tick_gen #(
    .DIV          (DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_tick (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_run       (w_run),
    .o_blank_end (w_blank_end),
    .o_pre_end   (w_pre_end),
    .o_slot_end  (w_slot_end)
  );

  // New frame starts either from IDLE or when slot 3 wraps back to slot 0.
  assign w_take_snap = en && ((r_state == ST_IDLE) ||
                              ((r_state == ST_SHOW) && w_slot_end && (r_idx == D_TEN2)));

  // Pattern for the digit of the current slot. SHOW is only ever entered
  // from BLANK of the same slot, so r_idx selects the digit to light next.
  always_comb begin
    w_bcd = r_snap_one1;
    case (r_idx)
      D_ONE1:  w_bcd = r_snap_one1;
      D_TEN1:  w_bcd = r_snap_ten1;
      D_ONE2:  w_bcd = r_snap_one2;
      default: w_bcd = r_snap_ten2;
    endcase

    w_pat = bcd_to_seg(w_bcd);
    // Odd slots are tens digits
    if (LZ_BLANK && r_idx[0] && (w_bcd == 4'd0)) begin
      w_pat = SEG_NONE;
    end

    w_seg_lit   = SEG_ACTIVE_LOW ? ~w_pat : w_pat;
    w_an_onehot = 4'b0001 << r_idx;
    w_an_lit    = AN_ACTIVE_LOW ? ~w_an_onehot : w_an_onehot;
  end

  // seg/an are loaded with the values for the next state, so pins switch on
  // the same edge as the state itself and never disagree with each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_idx        <= D_ONE1;
      r_frame_done <= 1'b0;
      r_seg        <= SEG_OFF;
      r_an         <= AN_OFF;
      r_snap_one1  <= 4'd0;
      r_snap_ten1  <= 4'd0;
      r_snap_one2  <= 4'd0;
      r_snap_ten2  <= 4'd0;
    end else begin
      // Raised one cycle early so the pulse sits on the last cycle of slot 3.
      // w_pre_end requires en, so a frame cut short never reports done.
      r_frame_done <= w_pre_end && (r_idx == D_TEN2);

      if (w_take_snap) begin
        r_snap_one1 <= one1;
        r_snap_ten1 <= ten1;
        r_snap_one2 <= one2;
        r_snap_ten2 <= ten2;
      end

      if (!en) begin
        r_state <= ST_IDLE;
        r_idx   <= D_ONE1;
        r_seg   <= SEG_OFF;
        r_an    <= AN_OFF;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_BLANK;
            r_idx   <= D_ONE1;
            r_seg   <= SEG_OFF;
            r_an    <= AN_OFF;
          end
          ST_BLANK: begin
            if (w_blank_end) begin
              r_state <= ST_SHOW;
              r_seg   <= w_seg_lit;
              r_an    <= w_an_lit;
            end
          end
          ST_SHOW: begin
            if (w_slot_end) begin
              r_state <= ST_BLANK;
              r_idx   <= r_idx + 2'd1;
              r_seg   <= SEG_OFF;
              r_an    <= AN_OFF;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_idx   <= D_ONE1;
            r_seg   <= SEG_OFF;
            r_an    <= AN_OFF;
          end
        endcase
      end
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign digit_idx  = r_idx;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - self-checking bench for seg_scan_mux with a frame-position model

module tb_seg_scan_mux;

  localparam int DIV   = 10;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * DIV;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] one1, ten1, one2, ten2;
  logic [6:0] seg_a, seg_b;
  logic [3:0] an_a, an_b;
  logic [1:0] idx_a, idx_b;
  logic       fd_a, fd_b;

  int n_checks;
  int n_fail;

  // Active-low segment patterns for 0..9, {g,f,e,d,c,b,a}
  logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  seg_scan_mux #(
    .CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYCLES(BLANK),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .one1(one1), .ten1(ten1), .one2(one2), .ten2(ten2),
    .seg(seg_a), .an(an_a), .digit_idx(idx_a), .frame_done(fd_a)
  );

  seg_scan_mux #(
    .CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYCLES(BLANK),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b0)
  ) dut_nl (
    .clk(clk), .rst_n(rst_n), .en(en),
    .one1(one1), .ten1(ten1), .one2(one2), .ten2(ten2),
    .seg(seg_b), .an(an_b), .digit_idx(idx_b), .frame_done(fd_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: position m_k within the frame since the display was enabled.
  bit         m_act;
  int         m_k;
  logic [3:0] m_snap [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act <= 1'b0;
      m_k   <= 0;
      for (int i = 0; i < 4; i++) m_snap[i] <= 4'd0;
    end else if (!en) begin
      m_act <= 1'b0;
      m_k   <= 0;
    end else if (!m_act || m_k == FRAME - 1) begin
      m_act     <= 1'b1;
      m_k       <= m_act ? (m_k + 1) % FRAME : 0;
      m_snap[0] <= one1;
      m_snap[1] <= ten1;
      m_snap[2] <= one2;
      m_snap[3] <= ten2;
    end else begin
      m_k <= m_k + 1;
    end
  end

  function automatic void model_out(input bit lz, output logic [3:0] e_an, output logic [6:0] e_seg,
                                    output logic [1:0] e_idx, output logic e_fd);
    int slot;
    int w;
    logic [3:0] d;
    slot  = m_k / DIV;
    w     = m_k % DIV;
    e_an  = 4'hF;
    e_seg = 7'h7F;
    e_idx = 2'd0;
    e_fd  = 1'b0;
    if (m_act) begin
      e_idx = 2'(slot);
      e_fd  = (m_k == FRAME - 1);
      if (w >= BLANK) begin
        e_an = ~(4'b0001 << slot);
        d    = m_snap[slot];
        if (d <= 4'd9 && !(lz && (slot % 2 == 1) && d == 4'd0)) e_seg = seg_tbl[d];
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic [1:0] e_idx;
    logic       e_fd;
    if (rst_n) begin
      model_out(1'b1, e_an, e_seg, e_idx, e_fd);
      chk("lz_an", 32'(an_a), 32'(e_an));
      chk("lz_seg", 32'(seg_a), 32'(e_seg));
      chk("lz_idx", 32'(idx_a), 32'(e_idx));
      chk("lz_fd", 32'(fd_a), 32'(e_fd));
      model_out(1'b0, e_an, e_seg, e_idx, e_fd);
      chk("nl_an", 32'(an_b), 32'(e_an));
      chk("nl_seg", 32'(seg_b), 32'(e_seg));
      chk("nl_idx", 32'(idx_b), 32'(e_idx));
      chk("nl_fd", 32'(fd_b), 32'(e_fd));
    end
  end

  // Advance to the negedge where the model sits at frame position target
  task automatic go_k(input int target);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_act && m_k == target) && n < 100);
    if (!(m_act && m_k == target)) begin
      n_checks++;
      n_fail++;
      $display("FAIL go_k timeout: position %0d not reached within 100 cycles", target);
    end
  endtask

  initial begin
    int cnt;
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    one1 = 4'd5; ten1 = 4'd2; one2 = 4'd9; ten2 = 4'd1;

    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an_a), 32'h0F);
    chk("rst_seg", 32'(seg_a), 32'h7F);
    chk("rst_idx", 32'(idx_a), 32'd0);
    chk("rst_fd", 32'(fd_a), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;

    // Normal frame 5,2,9,1
    go_k(1);  chk("nf_blank_an", 32'(an_a), 32'b1111);
    go_k(2);  chk("nf_s0_an", 32'(an_a), 32'b1110); chk("nf_s0_seg", 32'(seg_a), 32'b0010010);
    go_k(12); chk("nf_s1_an", 32'(an_a), 32'b1101); chk("nf_s1_seg", 32'(seg_a), 32'b0100100);
    go_k(22); chk("nf_s2_an", 32'(an_a), 32'b1011); chk("nf_s2_seg", 32'(seg_a), 32'b0010000);
    go_k(32); chk("nf_s3_an", 32'(an_a), 32'b0111); chk("nf_s3_seg", 32'(seg_a), 32'b1111001);
    go_k(38); chk("nf_fd_early", 32'(fd_a), 32'd0);
    go_k(39); chk("nf_fd", 32'(fd_a), 32'd1); chk("nf_fd_idx", 32'(idx_a), 32'd3);
    cnt = 0;
    repeat (FRAME) begin
      @(negedge clk);
      cnt += int'(fd_a);
    end
    chk("nf_fd_per_frame", 32'(cnt), 32'd1);

    // Leading-zero blanking; one2=3 for the tear test
    one1 = 4'd7; ten1 = 4'd0; one2 = 4'd3; ten2 = 4'd4;
    go_k(2);  chk("lz_s0_seg", 32'(seg_a), 32'b1111000);
    go_k(12); chk("lz_s1_an", 32'(an_a), 32'b1101); chk("lz_s1_seg", 32'(seg_a), 32'b1111111);
    chk("nolz_s1_seg", 32'(seg_b), 32'b1000000);
    go_k(15); one2 = 4'd4;
    go_k(22); chk("tear_old_seg", 32'(seg_a), 32'b0110000);
    go_k(22); chk("tear_new_seg", 32'(seg_a), 32'b0011001);

    // Invalid BCD
    one2 = 4'hC;
    go_k(22); chk("bad_an", 32'(an_a), 32'b1011); chk("bad_seg", 32'(seg_a), 32'b1111111);

    // Enable toggle in cycle 5 of slot 2
    go_k(25);
    en = 1'b0;
    @(negedge clk);
    chk("en_off_an", 32'(an_a), 32'b1111);
    chk("en_off_seg", 32'(seg_a), 32'b1111111);
    chk("en_off_idx", 32'(idx_a), 32'd0);
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      cnt += int'(fd_a);
    end
    chk("en_off_no_fd", 32'(cnt), 32'd0);
    en = 1'b1;
    @(negedge clk); chk("reen_k0_an", 32'(an_a), 32'b1111);
    @(negedge clk); chk("reen_k1_an", 32'(an_a), 32'b1111);
    @(negedge clk); chk("reen_k2_an", 32'(an_a), 32'b1110);

    // Asynchronous reset in the middle of SHOW
    go_k(5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_an", 32'(an_a), 32'b1111);
    chk("arst_seg", 32'(seg_a), 32'b1111111);
    chk("arst_idx", 32'(idx_a), 32'd0);
    chk("arst_fd", 32'(fd_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised phase, checked every cycle by the compare process
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(3))
          0: one1 = 4'($urandom_range(15));
          1: ten1 = 4'($urandom_range(15));
          2: one2 = 4'($urandom_range(15));
          default: ten2 = 4'($urandom_range(15));
        endcase
      end
      if (en && $urandom_range(99) == 0) en = 1'b0;
      else if (!en && $urandom_range(4) == 0) en = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Time-multiplexed 7-segment display driver for the two traffic-light countdowns.
- Sits directly downstream of the binary-to-BCD stage. It takes the four BCD digits (ONE1, TEN1, ONE2, TEN2) and drives one shared segment bus plus four digit-enable (anode) lines.
- Each digit is scanned in turn, with anti-ghosting blanking, leading-zero suppression and tear-free per-frame sampling.

Parameters:
- CLK_HZ, 50000000: input clock frequency in Hz.
- SCAN_HZ, 1000: digit slot rate in Hz. Slot length is DIV = CLK_HZ/SCAN_HZ cycles.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off. Must satisfy 1 <= BLANK_CYCLES < DIV.
- SEG_ACTIVE_LOW, 1: when 1, a lit segment drives 0.
- AN_ACTIVE_LOW, 1: when 1, an enabled digit drives 0.
- LZ_BLANK, 1: when 1, a tens digit equal to 0 is blanked.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset. Asynchronous assert, active-low.
- en, input, 1: display enable. When 0, all digits are dark.
- one1, input, 4: BCD ones digit, road 1.
- ten1, input, 4: BCD tens digit, road 1.
- one2, input, 4: BCD ones digit, road 2.
- ten2, input, 4: BCD tens digit, road 2.
- seg, output, 7: segment bus {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- an, output, 4: digit enables, one-hot when active, polarity per AN_ACTIVE_LOW.
- digit_idx, output, 2: index of the slot in progress.
- frame_done, output, 1: one-cycle pulse on the last cycle of slot 3.

Behaviour:
- **Reset (rst_n=0, asynchronous):**
  - state = IDLE, slot counter = 0, digit_idx = 0, frame_done = 0.
  - Snapshot registers = 0.
  - an = all inactive; seg = all segments off (respecting polarities).
- **Slot order:** digit_idx 0 = one1, 1 = ten1, 2 = one2, 3 = ten2. After 3 it wraps to 0.
- **Slot counter:** runs 0..DIV-1 and wraps. End of slot = count reaches DIV-1.
- **FSM states:**
  - IDLE: an inactive, seg off, counter held at 0.
    - If en=1, go to BLANK next cycle with digit_idx = 0, and take the snapshot.
  - BLANK: an inactive, seg off.
    - When count = BLANK_CYCLES-1, go to SHOW.
  - SHOW: an[digit_idx] active; seg = decoded snapshot digit.
    - At count = DIV-1: advance digit_idx and go to BLANK.
    - If digit_idx was 3, also pulse frame_done and take a new snapshot.
- **Snapshot:** all four inputs are latched together, only at frame start (IDLE→BLANK, or wrap 3→0). Input changes mid-frame never tear a frame.
- **Decode:**
  - Standard hex-free BCD patterns, e.g. 0 lights a–f and 8 lights all seven segments.
  - Values 10–15 decode to all segments off.
  - If LZ_BLANK=1 and the tens snapshot = 0, that slot's segments are off. Its anode still follows the state machine.
- **Output latency:** seg and an are registered outputs. Pins change one cycle after the state/counter condition that causes them; this is the same cycle for both, so no glitch.
- **en deassert mid-slot:**
  - Next clock: IDLE, outputs dark, counter = 0, digit_idx = 0.
  - A partial frame produces no frame_done.
  - Re-assert restarts from slot 0 with a fresh snapshot.
- **Simultaneous events:** en falling on the frame_done cycle still emits frame_done. en has priority for the next state.
- **Per-digit timing:** digit duty = (DIV-BLANK_CYCLES)/DIV. Frame period = 4*DIV cycles.

Decomposition:
- Shared package (traffic display constants):
  - BCD→7-seg pattern constants.
  - Digit index constants (D_ONE1=0, D_TEN1=1, D_ONE2=2, D_TEN2=3).
  - FSM state encoding (IDLE, BLANK, SHOW).
- One natural sub-module: scan_tick_gen. It is a parameterised 0..DIV-1 counter that outputs slot_end and blank_end strobes, with sync clear on en=0.
- FSM, snapshot and decode remain in seg_scan_mux.

Test Plan:
All scenarios use CLK_HZ=1000, SCAN_HZ=100 (DIV=10), BLANK_CYCLES=2, active-low polarities.
1. **Reset mid-SHOW:** drop rst_n asynchronously → an=4'b1111 and seg=7'b1111111 immediately, without waiting for clk; digit_idx=0 and frame_done=0.
2. **Normal frame:** en=1, one1=5, ten1=2, one2=9, ten2=1.
   - Each slot: 2 dark cycles, then 8 cycles with an = 1110/1101/1011/0111 in turn.
   - seg = 0010010 (5), 0100100 (2), 0010000 (9), 1111001 (1).
   - frame_done high exactly once per 40 cycles.
3. **Leading-zero blanking:** ten1=0, one1=7, LZ_BLANK=1.
   - Slot 1: an=1101 but seg=1111111.
   - Slot 0: seg=1111000 (7).
   - With LZ_BLANK=0, slot 1 shows 1000000 (0).
4. **Tear-free snapshot:** change one2 from 3 to 4 during slot 1 → slot 2 still shows 3 this frame and shows 4 from the next frame.
5. **Enable toggle:** deassert en in cycle 5 of slot 2 → dark next cycle and no frame_done. Reassert en → the first lit anode is 1110 after 2 blank cycles.
6. **Invalid BCD:** one2=4'hC → slot 2 has seg=1111111 while an=1011 is active.
